// File: rtl/lifo_stack.sv
// lifo_stack: register-based LIFO with pop-on-read output register,
// combinational top-of-stack peek, and overflow/underflow pulses.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clear         synchronous flush (stored entries discarded)
//   push, din     write request and data
//   pop           read request; popped word appears on dout next cycle
//   dout          registered popped data (holds when nothing is popped)
//   dout_valid    one-cycle strobe for newly popped data
//   top           combinational peek of the top entry (0 when empty)
//   count         stored entries, 0..DEPTH
//   empty, full   count == 0 / count == DEPTH
//   overflow      one-cycle pulse, push dropped because stack was full
//   underflow     one-cycle pulse, pop with nothing to return
module lifo_stack #(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dv_q, dv_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [DATA_W-1:0] wr_data;

  logic [CNT_W-1:0]  top_cnt;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     nxt_idx;
  logic [DATA_W-1:0] top_val;
  logic              is_empty;
  logic              is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));

  // count-1 is only used as an index while the stack is non-empty,
  // and count is only used as a write index while not full, so the
  // truncation to AW bits never drops a meaningful bit.
  assign top_cnt  = count_q - CNT_W'(1);
  assign top_idx  = top_cnt[AW-1:0];
  assign nxt_idx  = count_q[AW-1:0];
  assign top_val  = is_empty ? '0 : mem_q[top_idx];

  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = nxt_idx;
    wr_data = din;
    if (clear) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b11: begin
          dv_d = 1'b1;
          if (is_empty) begin
            // Bypass: nothing stored, the pushed word is popped directly.
            dout_d = din;
          end else begin
            // Replace the top in place; old top goes out.
            dout_d = top_val;
            wr_en  = 1'b1;
            wr_idx = top_idx;
          end
        end
        2'b10: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + CNT_W'(1);
          end
        end
        2'b01: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else begin
            dout_d  = top_val;
            dv_d    = 1'b1;
            count_d = top_cnt;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is never reset; stale words are unreachable once count drops.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign top        = top_val;
  assign count      = count_q;
  assign empty      = is_empty;
  assign full       = is_full;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed scenarios plus randomized traffic against
// a queue-based stack model.
module tb_lifo_stack;

  localparam int DW = 11;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [DW-1:0] top;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [DW-1:0] stk [$];
  logic [DW-1:0] m_dout = '0;
  logic          m_dv = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  lifo_stack #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .push(push), .pop(pop), .din(din),
    .dout(dout), .dout_valid(dout_valid), .top(top),
    .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic void model_step(
    input logic r, input logic c, input logic pu,
    input logic po, input logic [DW-1:0] d);
    if (r) begin
      stk.delete();
      m_dout = '0;
      m_dv = 0; m_ovf = 0; m_unf = 0;
    end else if (c) begin
      stk.delete();
      m_dv = 0; m_ovf = 0; m_unf = 0;
    end else begin
      m_dv = 0; m_ovf = 0; m_unf = 0;
      if (pu && po) begin
        m_dv = 1;
        if (stk.size() == 0) m_dout = d;
        else begin
          m_dout = stk[stk.size()-1];
          stk[stk.size()-1] = d;
        end
      end else if (pu) begin
        if (stk.size() == DP) m_ovf = 1;
        else stk.push_back(d);
      end else if (po) begin
        if (stk.size() == 0) m_unf = 1;
        else begin
          m_dout = stk.pop_back();
          m_dv = 1;
        end
      end
    end
  endfunction

  task automatic step(input logic r, input logic c, input logic pu,
                      input logic po, input logic [DW-1:0] d);
    rst = r; clear = c; push = pu; pop = po; din = d;
    @(posedge clk);
    model_step(r, c, pu, po, d);
    #1;
    rst = 0; clear = 0; push = 0; pop = 0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    checks++;
    if ({count, empty, full, dout, dout_valid, overflow, underflow, top}
        !== {3'd0, 1'b1, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 11'h000}) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d e=%b f=%b dout=%h dv=%b o=%b u=%b top=%h, want 0 1 0 000 0 0 0 000",
               count, empty, full, dout, dout_valid, overflow, underflow, top);
    end
  endtask

  task automatic test_fill_overflow();
    step(1, 0, 0, 0, '0);
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 0, DW'(i));
    checks++;
    if ({full, count, top} !== {1'b1, 3'd4, 11'h004}) begin
      errors++;
      $display("FAIL fill: got full=%b cnt=%0d top=%h, want 1 4 004", full, count, top);
    end
    step(0, 0, 1, 0, 11'h7FF);
    checks++;
    if ({overflow, underflow, top, count} !== {1'b1, 1'b0, 11'h004, 3'd4}) begin
      errors++;
      $display("FAIL overflow: got ovf=%b unf=%b top=%h cnt=%0d, want 1 0 004 4",
               overflow, underflow, top, count);
    end
    step(0, 0, 0, 0, '0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_pulse: got %b want 0", overflow);
    end
  endtask

  task automatic test_drain_underflow();
    for (int i = 4; i >= 1; i--) begin
      step(0, 0, 0, 1, '0);
      checks++;
      if ({dout, dout_valid} !== {DW'(i), 1'b1}) begin
        errors++;
        $display("FAIL drain_%0d: got dout=%h dv=%b, want %h 1", i, dout, dout_valid, DW'(i));
      end
    end
    step(0, 0, 0, 0, '0);
    checks++;
    if ({dout_valid, empty, top} !== {1'b0, 1'b1, 11'h000}) begin
      errors++;
      $display("FAIL drained: got dv=%b empty=%b top=%h, want 0 1 000", dout_valid, empty, top);
    end
    step(0, 0, 0, 1, '0);
    checks++;
    if ({underflow, overflow, dout, dout_valid, count} !== {1'b1, 1'b0, 11'h001, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL underflow: got unf=%b ovf=%b dout=%h dv=%b cnt=%0d, want 1 0 001 0 0",
               underflow, overflow, dout, dout_valid, count);
    end
  endtask

  task automatic test_push_pop();
    step(1, 0, 0, 0, '0);
    step(0, 0, 1, 0, 11'h010);
    step(0, 0, 1, 0, 11'h020);
    step(0, 0, 1, 1, 11'h0AA);
    checks++;
    if ({dout, dout_valid, count, top, overflow} !== {11'h020, 1'b1, 3'd2, 11'h0AA, 1'b0}) begin
      errors++;
      $display("FAIL push_pop: got dout=%h dv=%b cnt=%0d top=%h ovf=%b, want 020 1 2 0aa 0",
               dout, dout_valid, count, top, overflow);
    end
  endtask

  task automatic test_bypass();
    step(1, 0, 0, 0, '0);
    step(0, 0, 1, 1, 11'h155);
    checks++;
    if ({dout, dout_valid, count, overflow, underflow} !== {11'h155, 1'b1, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL bypass: got dout=%h dv=%b cnt=%0d o=%b u=%b, want 155 1 0 0 0",
               dout, dout_valid, count, overflow, underflow);
    end
  endtask

  task automatic test_clear();
    step(1, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, DW'(i + 5));
    step(0, 1, 1, 0, 11'h333);
    checks++;
    if ({count, empty, top, dout_valid} !== {3'd0, 1'b1, 11'h000, 1'b0}) begin
      errors++;
      $display("FAIL clear: got cnt=%0d empty=%b top=%h dv=%b, want 0 1 000 0",
               count, empty, top, dout_valid);
    end
    step(0, 0, 0, 1, '0);
    checks++;
    if ({underflow, dout_valid} !== {1'b1, 1'b0}) begin
      errors++;
      $display("FAIL clear_pop: got unf=%b dv=%b, want 1 0", underflow, dout_valid);
    end
  endtask

  task automatic test_mid_reset();
    step(0, 0, 1, 0, 11'h0F0);
    step(0, 0, 1, 1, 11'h0F1);
    step(0, 0, 1, 0, 11'h0F2);
    step(1, 0, 0, 0, '0);
    checks++;
    if ({count, empty, full, dout, dout_valid, overflow, underflow}
        !== {3'd0, 1'b1, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got cnt=%0d e=%b f=%b dout=%h dv=%b o=%b u=%b, want 0 1 0 000 0 0 0",
               count, empty, full, dout, dout_valid, overflow, underflow);
    end
    step(0, 0, 0, 1, '0);
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL reset_pop: got unf=%b want 1", underflow);
    end
  endtask

  task automatic test_random();
    logic r, c, pu, po;
    logic [DW-1:0] d;
    logic [DW-1:0] mt;
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 99) == 0);
      c  = ($urandom_range(0, 39) == 0);
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      d  = DW'($urandom);
      step(r, c, pu, po, d);
      mt = (stk.size() == 0) ? '0 : stk[stk.size()-1];
      checks++;
      if ({count, empty, full, top, dout, dout_valid, overflow, underflow}
          !== {CW'(stk.size()), stk.size() == 0, stk.size() == DP,
               mt, m_dout, m_dv, m_ovf, m_unf}) begin
        errors++;
        $display("FAIL random_%0d: got cnt=%0d top=%h dout=%h dv=%b o=%b u=%b, want %0d %h %h %b %b %b",
                 n, count, top, dout, dout_valid, overflow, underflow,
                 stk.size(), mt, m_dout, m_dv, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_push_pop();
    test_bypass();
    test_clear();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
